snake_turn_queue: RTL and testbench

- Multi-player steering controller. Converts left/right turn requests (mouse buttons or equivalent) into one registered snake direction per player.
- Turn requests are edge-detected and buffered in a per-player FIFO. One buffered turn is applied per game step. A game step is a rising edge of the divided game clock.
- Sits between the input decoders and the snake movement/collision logic. Replaces single-player, single-turn steering.

---
 rtl/snake_turn_queue.sv | 181 ++++++++++++++++++
 tb/tb_snake_turn_queue.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/snake_turn_queue.sv
// Multi-lane snake steering: edge-detected left/right turns are queued per lane and one is applied per game step.
// Optional absolute (keyboard-style) steering is enabled by defining SNAKE_TURN_ABS_EN.

package snake_pkg;
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;
endpackage

module snake_turn_queue
  import snake_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int QUEUE_DEPTH = 4,
  parameter int CNT_W       = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_divided,
  input  logic [NUM_PLAYERS-1:0]       left,
  input  logic [NUM_PLAYERS-1:0]       right,
  input  logic [NUM_PLAYERS-1:0]       freeze,
`ifdef SNAKE_TURN_ABS_EN
  input  logic [NUM_PLAYERS-1:0]       abs_valid,
  input  logic [2*NUM_PLAYERS-1:0]     abs_dir,
`endif
  output logic [2*NUM_PLAYERS-1:0]     dir,
  output logic                         step,
  output logic [CNT_W*NUM_PLAYERS-1:0] pending,
  output logic [NUM_PLAYERS-1:0]       overflow
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

  // IDLE must be the all-zero code so it agrees with an empty queue out of reset.
  typedef enum logic {
    LANE_IDLE   = 1'b0,
    LANE_QUEUED = 1'b1
  } lane_state_t;

  // Relative turn table; an unknown heading recovers to UP.
  function automatic logic [1:0] turn(input logic [1:0] cur, input logic go_right);
    case (cur)
      DIR_UP:    turn = go_right ? DIR_RIGHT : DIR_LEFT;
      DIR_DOWN:  turn = go_right ? DIR_LEFT  : DIR_RIGHT;
      DIR_LEFT:  turn = go_right ? DIR_UP    : DIR_DOWN;
      DIR_RIGHT: turn = go_right ? DIR_DOWN  : DIR_UP;
      default:   turn = DIR_UP;
    endcase
  endfunction

  logic clk_div_prev;
  logic step_int;

  assign step_int = clk_divided & ~clk_div_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_div_prev <= 1'b0;
      step         <= 1'b0;
    end else begin
      clk_div_prev <= clk_divided;
      step         <= step_int;
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : lane
    logic [QUEUE_DEPTH-1:0] fifo;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [CNT_W-1:0]       count;
    logic [1:0]             cur_dir;
    logic                   ovf;
    logic                   left_prev;
    logic                   right_prev;
    lane_state_t            state;

    logic push_l, push_r, push_any, full, pop, accept, drop;

    // Simultaneous left and right edges cancel out rather than guessing a winner.
    assign push_l   = left[g] & ~left_prev;
    assign push_r   = right[g] & ~right_prev;
    assign push_any = push_l ^ push_r;
    assign full     = (count == CNT_W'(QUEUE_DEPTH));
    assign pop      = step_int & ~freeze[g] & (count != '0);
    assign accept   = push_any & (~full | pop);
    assign drop     = push_any & full & ~pop;

`ifdef SNAKE_TURN_ABS_EN
    logic       abs_prev;
    logic       slot_valid;
    logic [1:0] slot_dir;
    logic       abs_load;

    // With this encoding the reverse heading differs only in the upper bit.
    assign abs_load = abs_valid[g] & ~abs_prev &
                      (abs_dir[2*g +: 2] != (cur_dir ^ 2'b10));
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        fifo       <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        count      <= '0;
        cur_dir    <= DIR_UP;
        ovf        <= 1'b0;
        left_prev  <= 1'b0;
        right_prev <= 1'b0;
        state      <= LANE_IDLE;
`ifdef SNAKE_TURN_ABS_EN
        abs_prev   <= 1'b0;
        slot_valid <= 1'b0;
        slot_dir   <= DIR_UP;
`endif
      end else begin
        left_prev  <= left[g];
        right_prev <= right[g];
`ifdef SNAKE_TURN_ABS_EN
        abs_prev   <= abs_valid[g];
        // An absolute request replaces everything queued and suppresses this cycle's relative traffic.
        if (abs_load) begin
          rd_ptr     <= '0;
          wr_ptr     <= '0;
          count      <= CNT_W'(1);
          slot_valid <= 1'b1;
          slot_dir   <= abs_dir[2*g +: 2];
          state      <= LANE_QUEUED;
        end else begin
`endif
          if (accept) begin
            fifo[wr_ptr] <= push_r;
            wr_ptr       <= wr_ptr + PTR_W'(1);
          end
          if (pop) begin
`ifdef SNAKE_TURN_ABS_EN
            if (slot_valid) begin
              cur_dir    <= slot_dir;
              slot_valid <= 1'b0;
            end else begin
              cur_dir <= turn(cur_dir, fifo[rd_ptr]);
              rd_ptr  <= rd_ptr + PTR_W'(1);
            end
`else
            cur_dir <= turn(cur_dir, fifo[rd_ptr]);
            rd_ptr  <= rd_ptr + PTR_W'(1);
`endif
          end
          if (accept && !pop) begin
            count <= count + CNT_W'(1);
          end else if (pop && !accept) begin
            count <= count - CNT_W'(1);
          end
          if (drop) begin
            ovf <= 1'b1;
          end
          case (state)
            LANE_IDLE:   if (accept) state <= LANE_QUEUED;
            LANE_QUEUED: if (pop && !accept && count == CNT_W'(1)) state <= LANE_IDLE;
            default:     state <= LANE_IDLE;
          endcase
`ifdef SNAKE_TURN_ABS_EN
        end
`endif
      end
    end

    // The explicit lane state must always agree with the occupancy count.
    state_matches_count: assert property (
      @(posedge clk) disable iff (rst) ((state == LANE_QUEUED) == (count != '0))
    );

    assign dir[2*g +: 2]         = cur_dir;
    assign pending[CNT_W*g +: CNT_W] = count;
    assign overflow[g]           = ovf;
  end

endmodule

// File: tb/tb_snake_turn_queue.sv
// Randomized and directed bench for snake_turn_queue against a queue-of-turns heading model.
module tb_snake_turn_queue;
  import snake_pkg::*;

  localparam int NP = 2;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              clk_divided;
  logic [NP-1:0]     left;
  logic [NP-1:0]     right;
  logic [NP-1:0]     freeze;
  logic [2*NP-1:0]   dir;
  logic              step;
  logic [CW*NP-1:0]  pending;
  logic [NP-1:0]     overflow;

  int compared   = 0;
  int mismatched = 0;

  // Model: heading as a compass index (0 N, 1 E, 2 S, 3 W) and a queue of turns per lane.
  bit m_q [NP][$];
  int m_hdg [NP];
  bit m_ovf [NP];
  bit m_lp [NP];
  bit m_rp [NP];
  bit m_cdp;
  bit m_step;

  logic [NP-1:0] frz = '0;

  snake_turn_queue #(.NUM_PLAYERS(NP), .QUEUE_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .clk_divided(clk_divided),
    .left(left), .right(right), .freeze(freeze),
    .dir(dir), .step(step), .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] heading_code(input int h);
    case (h)
      0:       heading_code = DIR_UP;
      1:       heading_code = DIR_RIGHT;
      2:       heading_code = DIR_DOWN;
      default: heading_code = DIR_LEFT;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelEdge(input bit rv, input bit cdv, input logic [NP-1:0] lv,
                           input logic [NP-1:0] rtv, input logic [NP-1:0] fv);
    bit st, pl, pr, popping;
    int size;
    if (rv) begin
      for (int i = 0; i < NP; i++) begin
        m_q[i].delete();
        m_hdg[i] = 0; m_ovf[i] = 0; m_lp[i] = 0; m_rp[i] = 0;
      end
      m_cdp = 0; m_step = 0;
    end else begin
      st = cdv && !m_cdp;
      for (int i = 0; i < NP; i++) begin
        pl = lv[i] && !m_lp[i];
        pr = rtv[i] && !m_rp[i];
        size = m_q[i].size();
        popping = st && !fv[i] && size > 0;
        if (popping) begin
          m_hdg[i] = m_q[i].pop_front() ? (m_hdg[i] + 1) % 4 : (m_hdg[i] + 3) % 4;
        end
        if (pl != pr) begin
          if (size < D || popping) m_q[i].push_back(pr);
          else m_ovf[i] = 1;
        end
        m_lp[i] = lv[i];
        m_rp[i] = rtv[i];
      end
      m_step = st;
      m_cdp = cdv;
    end
  endtask

  // One clock: drive inputs, advance the model, then compare every output after the edge.
  task automatic applyStimulus(input bit rv, input bit cdv, input logic [NP-1:0] lv,
                               input logic [NP-1:0] rtv);
    rst = rv; clk_divided = cdv; left = lv; right = rtv; freeze = frz;
    modelEdge(rv, cdv, lv, rtv, frz);
    @(posedge clk);
    #1;
    checkOutput("step", 32'(step), 32'(m_step));
    for (int i = 0; i < NP; i++) begin
      checkOutput($sformatf("dir%0d", i), 32'(dir[2*i +: 2]), 32'(heading_code(m_hdg[i])));
      checkOutput($sformatf("pending%0d", i), 32'(pending[CW*i +: CW]), 32'(m_q[i].size()));
      checkOutput($sformatf("overflow%0d", i), 32'(overflow[i]), 32'(m_ovf[i]));
    end
  endtask

  task automatic pulse(input logic [NP-1:0] lv, input logic [NP-1:0] rtv);
    applyStimulus(0, 0, lv, rtv);
    applyStimulus(0, 0, '0, '0);
  endtask

  task automatic gameStep();
    applyStimulus(0, 1, '0, '0);
    applyStimulus(0, 0, '0, '0);
  endtask

  task automatic doReset();
    applyStimulus(1, 0, '0, '0);
    applyStimulus(0, 0, '0, '0);
  endtask

  initial begin
    logic [NP-1:0] lr, rr;
    bit cd;
    rst = 1'b1; clk_divided = 1'b0; left = '0; right = '0; freeze = '0;

    // Reset, then three idle steps.
    doReset();
    for (int k = 0; k < 3; k++) gameStep();
    checkOutput("rst_dir", 32'(dir), 32'({DIR_UP, DIR_UP}));
    checkOutput("rst_pending", 32'(pending), 0);
    checkOutput("rst_overflow", 32'(overflow), 0);

    // Single left turn on lane 0.
    pulse(2'b01, 2'b00);
    applyStimulus(0, 1, '0, '0);
    checkOutput("one_left_dir0", 32'(dir[1:0]), 32'(DIR_LEFT));
    checkOutput("one_left_dir1", 32'(dir[3:2]), 32'(DIR_UP));
    checkOutput("one_left_step", 32'(step), 1);
    applyStimulus(0, 0, '0, '0);
    checkOutput("step_once", 32'(step), 0);

    // left, left, right queued then drained.
    doReset();
    pulse(2'b01, 2'b00); pulse(2'b01, 2'b00); pulse(2'b00, 2'b01);
    checkOutput("llr_pending", 32'(pending[2:0]), 3);
    applyStimulus(0, 1, '0, '0);
    checkOutput("llr_dir_a", 32'(dir[1:0]), 32'(DIR_LEFT));
    checkOutput("llr_pend_a", 32'(pending[2:0]), 2);
    applyStimulus(0, 0, '0, '0);
    applyStimulus(0, 1, '0, '0);
    checkOutput("llr_dir_b", 32'(dir[1:0]), 32'(DIR_DOWN));
    checkOutput("llr_pend_b", 32'(pending[2:0]), 1);
    applyStimulus(0, 0, '0, '0);
    applyStimulus(0, 1, '0, '0);
    checkOutput("llr_dir_c", 32'(dir[1:0]), 32'(DIR_LEFT));
    checkOutput("llr_pend_c", 32'(pending[2:0]), 0);
    applyStimulus(0, 0, '0, '0);

    // Overflow: five rights into a four-deep queue.
    doReset();
    for (int k = 0; k < 5; k++) pulse(2'b00, 2'b01);
    checkOutput("ovf_pending", 32'(pending[2:0]), 4);
    checkOutput("ovf_flag", 32'(overflow[0]), 1);
    for (int k = 0; k < 4; k++) gameStep();
    checkOutput("ovf_dir_after", 32'(dir[1:0]), 32'(DIR_UP));
    checkOutput("ovf_sticky", 32'(overflow[0]), 1);

    // Freeze on lane 1.
    doReset();
    pulse(2'b10, 2'b00); pulse(2'b10, 2'b00);
    frz = 2'b10;
    gameStep(); gameStep();
    checkOutput("frz_dir1", 32'(dir[3:2]), 32'(DIR_UP));
    checkOutput("frz_pending1", 32'(pending[5:3]), 2);
    frz = 2'b00;
    gameStep();
    checkOutput("unfrz_dir1", 32'(dir[3:2]), 32'(DIR_LEFT));
    checkOutput("unfrz_pending1", 32'(pending[5:3]), 1);

    // Both buttons together, push while full during a step, reset with entries queued.
    doReset();
    applyStimulus(0, 0, 2'b01, 2'b01);
    checkOutput("both_pending", 32'(pending[2:0]), 0);
    applyStimulus(0, 0, '0, '0);
    for (int k = 0; k < 4; k++) pulse(2'b00, 2'b01);
    applyStimulus(0, 1, 2'b00, 2'b01);
    checkOutput("full_pop_pending", 32'(pending[2:0]), 4);
    checkOutput("full_pop_ovf", 32'(overflow[0]), 0);
    checkOutput("full_pop_dir", 32'(dir[1:0]), 32'(DIR_RIGHT));
    applyStimulus(0, 0, '0, '0);
    doReset();
    for (int k = 0; k < 3; k++) pulse(2'b01, 2'b00);
    applyStimulus(1, 0, '0, '0);
    checkOutput("mid_rst_pending", 32'(pending), 0);
    checkOutput("mid_rst_dir", 32'(dir), 32'({DIR_UP, DIR_UP}));

    // Random traffic with random game-clock phase, freezes and occasional resets.
    doReset();
    lr = '0; rr = '0; cd = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NP; i++) begin
        if ($urandom_range(0, 3) == 0) lr[i] = ~lr[i];
        if ($urandom_range(0, 3) == 0) rr[i] = ~rr[i];
        if ($urandom_range(0, 19) == 0) frz[i] = ~frz[i];
      end
      if ($urandom_range(0, 4) == 0) cd = ~cd;
      applyStimulus($urandom_range(0, 299) == 0, cd, lr, rr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
